// File: rtl/clock_enable_gen_if.sv
// Clock-enable bus: divide-select and hold requests in, per-channel
// enable pulses and divided level out. Clock and reset stay plain ports.
interface clock_enable_gen_if #(
  parameter int CHANNELS = 2
);
  logic [2*CHANNELS-1:0] sel;
  logic [CHANNELS-1:0]   hold;
  logic [CHANNELS-1:0]   ce_p;
  logic [CHANNELS-1:0]   ce_n;
  logic [CHANNELS-1:0]   lvl;

  // Requester side: chooses ratios and suppresses pulses.
  modport master (output sel, hold, input ce_p, ce_n, lvl);
  // Generator side.
  modport slave  (input sel, hold, output ce_p, ce_n, lvl);
endinterface

// File: rtl/clock_enable_gen.sv
// Clock-enable generator: one free-running W-bit counter shared by all
// channels; each channel taps it at a run-time selectable bit to produce
// rising/falling enable pulses and a registered divided level.
module clock_enable_gen #(
  parameter int W        = 3,
  parameter int CHANNELS = 2,
  parameter int SEL_RST  = W - 1
) (
  input  logic               clock,
  input  logic               reset,
  clock_enable_gen_if.slave  bus
);

  localparam logic [1:0] S_MAX = 2'(W - 1);
  localparam logic [1:0] S_RST = 2'(SEL_RST);

  logic [W-1:0]        r_cnt;
  logic [1:0]          r_s [CHANNELS];
  logic [CHANNELS-1:0] r_ce_p;
  logic [CHANNELS-1:0] r_ce_n;
  logic [CHANNELS-1:0] r_lvl;

  logic                w_wrap;
  logic [1:0]          w_s    [CHANNELS];
  logic [W-1:0]        w_mask [CHANNELS];
  logic [CHANNELS-1:0] w_lvl;
  logic [CHANNELS-1:0] w_ce_p;
  logic [CHANNELS-1:0] w_ce_n;

  // Last count of the period: the only point where a new select may load,
  // and where every channel's level is about to return low.
  assign w_wrap = &r_cnt;

  // Free-running master counter; wraps naturally from all-ones to zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= r_cnt + 1'b1;
  end

  // Select registers reload only at the wrap so a new ratio starts on a
  // period boundary with a full low half-period.
  // NOTE: this small array holds control state and must come out of reset
  // with a known ratio, so every entry is reset explicitly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) r_s[k] <= S_RST;
    end else if (w_wrap) begin
      for (int k = 0; k < CHANNELS; k++) r_s[k] <= bus.sel[2*k +: 2];
    end
  end

  // Clamp each select to the counter width and decode the tap bit, the
  // low-bit mask, and the falling/rising patterns on the counter.
  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_lvl  = '0;
    w_ce_p = '0;
    w_ce_n = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_s[k]    = (r_s[k] > S_MAX) ? S_MAX : r_s[k];
      w_mask[k] = '0;
      for (int i = 0; i < W; i++) begin
        if (i <= int'(w_s[k])) w_mask[k][i] = 1'b1;
        if (i == int'(w_s[k])) w_lvl[k]     = r_cnt[i];
      end
      // Falling pattern: all selected bits one. Rising: top bit zero, rest one.
      w_ce_n[k] = ((r_cnt & w_mask[k]) == w_mask[k]);
      w_ce_p[k] = ((r_cnt & w_mask[k]) == (w_mask[k] >> 1));
    end
  end

  // Output registers: level follows the tap, pulses are dropped under hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ce_p <= '0;
      r_ce_n <= '0;
      r_lvl  <= '0;
    end else begin
      r_ce_p <= w_ce_p & ~bus.hold;
      r_ce_n <= w_ce_n & ~bus.hold;
      r_lvl  <= w_lvl;
    end
  end

  assign bus.ce_p = r_ce_p;
  assign bus.ce_n = r_ce_n;
  assign bus.lvl  = r_lvl;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: a behavioural model pushes the expected
// outputs for every clock edge into a queue; each test pops and compares
// after the edge, plus a few scenario-specific property checks.
module tb_clock_enable_gen;

  localparam int W       = 3;
  localparam int CH      = 2;
  localparam int SEL_RST = 2;
  localparam int NCNT    = 1 << W;

  logic clock = 1'b0;
  logic reset;

  clock_enable_gen_if #(.CHANNELS(CH)) bus ();

  clock_enable_gen #(
    .W        (W),
    .CHANNELS (CH),
    .SEL_RST  (SEL_RST)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Model state: counter value the next edge will sample, active selects.
  int m_cnt;
  int m_s [CH];
  logic [5:0] sb [$];

  function automatic int clamp_sel(input int v);
    return (v > W - 1) ? W - 1 : v;
  endfunction

  // Expected {ce_p, ce_n, lvl} per channel (channel k at bits 3k+2..3k),
  // derived from the phase within the channel's period.
  function automatic logic [5:0] model_out(input logic [CH-1:0] h);
    logic [5:0] v;
    v = '0;
    for (int k = 0; k < CH; k++) begin
      int per;
      int ph;
      per = 2 << m_s[k];
      ph  = m_cnt % per;
      v[3*k+2] = (ph == per / 2 - 1) && !h[k];
      v[3*k+1] = (ph == per - 1) && !h[k];
      v[3*k]   = (ph >= per / 2);
    end
    return v;
  endfunction

  function automatic logic [5:0] obs();
    return {bus.ce_p[1], bus.ce_n[1], bus.lvl[1],
            bus.ce_p[0], bus.ce_n[0], bus.lvl[0]};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < CH; k++) m_s[k] = SEL_RST;
    sb.delete();
  endtask

  // Predict the coming edge, advance the model, then step past the edge.
  task automatic tick();
    sb.push_back(model_out(bus.hold));
    if (m_cnt == NCNT - 1)
      for (int k = 0; k < CH; k++) m_s[k] = clamp_sel(int'(bus.sel[2*k +: 2]));
    m_cnt = (m_cnt + 1) % NCNT;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    reset    = 1'b1;
    bus.sel  = 4'b1010;
    bus.hold = 2'b00;
    #1;
    total++;
    if (obs() !== 6'b0) $display("FAIL reset_t0: got %b expected %b", obs(), 6'b0);
    else passed++;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (obs() !== 6'b0) $display("FAIL reset_held: got %b expected %b", obs(), 6'b0);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL reset_release c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
    end
  endtask

  task automatic test_default_ratio();
    logic [5:0] exp, prev;
    int n_p, n_hi;
    n_p = 0; n_hi = 0;
    prev = obs();
    for (int c = 0; c < 24; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL default c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
      if (prev[2]) begin
        total++;
        if (!(bus.lvl[0] && !prev[0]))
          $display("FAIL default_p_before_rise c%0d: lvl %b->%b expected 0->1", c, prev[0], bus.lvl[0]);
        else passed++;
      end
      if (prev[1]) begin
        total++;
        if (!(!bus.lvl[0] && prev[0]))
          $display("FAIL default_n_before_fall c%0d: lvl %b->%b expected 1->0", c, prev[0], bus.lvl[0]);
        else passed++;
      end
      n_p  += int'(bus.ce_p[0]);
      n_hi += int'(bus.lvl[0]);
      prev = obs();
    end
    total++;
    if (n_p !== 3 || n_hi !== 12)
      $display("FAIL default_period: ce_p %0d lvl_hi %0d expected 3 and 12", n_p, n_hi);
    else passed++;
  endtask

  task automatic test_mixed_ratio();
    logic [5:0] exp;
    bus.sel = {2'd2, 2'd1};
    for (int c = 0; c < 24; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL mixed c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
      if (bus.ce_n[1]) begin
        total++;
        if (bus.ce_n[0] !== 1'b1) $display("FAIL mixed_align c%0d: ce_n0 %b expected 1", c, bus.ce_n[0]);
        else passed++;
      end
    end
  endtask

  task automatic test_sel_switch();
    logic [5:0] exp;
    bus.sel = {2'd2, 2'd2};
    for (int c = 0; c < 16 && !(m_cnt == 3 && m_s[0] == 2); c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL switch_pre c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
    end
    bus.sel = {2'd2, 2'd0};
    for (int c = 0; c < 20; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL switch c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
    end
  endtask

  task automatic test_hold();
    logic [5:0] exp;
    bus.sel = {2'd2, 2'd2};
    for (int c = 0; c < 24 && !(m_s[0] == 2 && model_out(2'b00)[2]); c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL hold_pre c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
    end
    bus.hold = 2'b01;
    tick();
    bus.hold = 2'b00;
    exp = sb.pop_front();
    total++;
    if (obs() !== exp) $display("FAIL hold_cycle: got %b expected %b", obs(), exp);
    else passed++;
    total++;
    if (bus.ce_p[0] !== 1'b0 || bus.ce_p[1] !== 1'b1)
      $display("FAIL hold_drop: ce_p %b expected 10", bus.ce_p);
    else passed++;
    for (int c = 0; c < 16; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL hold_after c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
    end
  endtask

  task automatic test_clamp();
    logic [5:0] exp;
    int n_p, n_hi;
    n_p = 0; n_hi = 0;
    bus.sel = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL clamp_pre c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
      if (m_cnt == 0) break;
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL clamp c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
      n_p  += int'(bus.ce_p[0]);
      n_hi += int'(bus.lvl[0]);
    end
    total++;
    if (n_p !== 2 || n_hi !== 8)
      $display("FAIL clamp_period: ce_p %0d lvl_hi %0d expected 2 and 8", n_p, n_hi);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    bus.sel = {2'd2, 2'd0};
    for (int c = 0; c < 11; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL areset_pre c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== 6'b0) $display("FAIL areset_immediate: got %b expected %b", obs(), 6'b0);
    else passed++;
    @(posedge clock);
    #1;
    total++;
    if (obs() !== 6'b0) $display("FAIL areset_held: got %b expected %b", obs(), 6'b0);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 16; c++) begin
      tick();
      exp = sb.pop_front();
      total++;
      if (obs() !== exp) $display("FAIL areset_after c%0d: got %b expected %b", c, obs(), exp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_default_ratio();
    test_mixed_ratio();
    test_sel_switch();
    test_hold();
    test_clamp();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_enable_gen.md
# clock_enable_gen

Parametrised clock-enable generator for the system clock domain. A free-running master counter on the 28 MHz system clock produces per-channel rising- and falling-edge enable pulses and a registered divided level. Each channel's divide ratio is selectable at run time, with glitch-free switching, and each channel has a per-channel pulse-suppress input for contention and wait handling. It replaces fixed divided-clock taps: downstream logic runs on `clock` and qualifies on `ce_p` and `ce_n`.

## Interface
- `W`, default 3: master counter width; legal range 1..4; maximum divide ratio is 2^W.
- `CHANNELS`, default 2: number of independent enable channels.
- `SEL_RST`, default W-1: divide select loaded into every channel at reset.
- `clock`  in  1: system clock, 28 MHz nominal.
- `reset`  in  1: asynchronous, active-high reset.
- `sel`  in  2*CHANNELS: requested divide select per channel; channel k uses bits [2k+1:2k]; divide ratio = 2^(sel+1).
- `hold`  in  CHANNELS: per-channel pulse suppress, active high.
- `ce_p`  out  CHANNELS: one-cycle pulse in the cycle immediately before `lvl[k]` goes 0→1.
- `ce_n`  out  CHANNELS: one-cycle pulse in the cycle immediately before `lvl[k]` goes 1→0.
- `lvl`  out  CHANNELS: registered divided-clock level, 50% duty, for ports/visibility only; never used as a clock.

## Operation
- Master counter `cnt`, W bits:
  - Resets to 0; increments by 1 every `clock` cycle.
  - Wraps from 2^W-1 to 0.
  - Never stalls; `hold` does not affect it.
- Per channel k, active select `s`:
  - `s` is a 2-bit register.
  - The effective value is min(`s`, W-1): requests greater than or equal to W clamp to W-1.
- Select update:
  - `sel` for channel k is sampled into `s` only in the cycle where `cnt` == 2^W-1.
  - The new value governs comparisons from `cnt` == 0 onward.
  - Changes of `sel` at any other time have no effect until the next wrap.
- Registered outputs, updated each cycle from the current `cnt` and `s`:
  - `lvl[k]` <= `cnt[s]`.
  - `ce_n[k]` <= (`cnt[s:0]` == all ones) & ~`hold[k]`.
  - `ce_p[k]` <= (`cnt[s:0]` == 0 followed by s ones) & ~`hold[k]`. For s=0 this means `cnt[0]`==0.
- Glitch-free switching:
  - At `cnt` == 2^W-1 every channel's `ce_n` condition is true, so every `lvl` is 0 after the boundary.
  - A new ratio therefore always starts with a full low half-period.
  - `lvl` never produces a high or low phase shorter than the shorter of the old and new half-periods.
- `hold`:
  - Suppresses the pulse that would be registered in that cycle. The pulse is dropped, not deferred.
  - `lvl` keeps toggling and phase is never disturbed.
  - The outputs of other channels are unaffected.
- Channels are fully independent apart from the shared counter. With equal `s`, pulses are always phase-aligned.

## Timing
- Reset values: `cnt`=0; `s`=`SEL_RST` for all channels; `ce_p`, `ce_n` and `lvl` are all 0.
- Reset is asynchronous on assertion and takes effect immediately mid-period. No partial pulse is emitted after release.
- First cycles after reset release (s≥1): the first rising edge of `clock` samples `cnt`=0, so the registered outputs stay 0.
- Pulse period for channel k is 2^(s+1) cycles:
  - `ce_p` and `ce_n` are each exactly 1 cycle wide.
  - `ce_p` and `ce_n` are separated by 2^s cycles.
  - For s=0 (divide 2), `ce_p` and `ce_n` alternate every cycle.
- Latency: one cycle from the `cnt` pattern to the output; `hold` is sampled in the same cycle as the pattern.
- Simultaneous events:
  - A `sel` change and `hold` in the wrap cycle: the select update happens and the pulse is suppressed, independently.
  - `reset` overrides everything.

## Test plan
- Reset, default W=3, `SEL_RST`=2 → `ce_p`, `ce_n` and `lvl` are 0. After release:
  - channel `lvl` has period 8 cycles, 4 high / 4 low (3.5 MHz at 28 MHz);
  - `ce_p` precedes each `lvl` rise by exactly one cycle;
  - `ce_n` precedes each `lvl` fall by exactly one cycle.
- `sel`=1 on channel 0, 2 on channel 1 → channel 0 has period 4 (7 MHz) and channel 1 has period 8. Every channel-1 `ce_n` coincides with a channel-0 `ce_n`.
- Change channel 0 `sel` from 2 to 0 mid-period (`cnt`=3) → no change until the `cnt`=7 wrap. Afterwards channel 0 has period 2 and no `lvl` phase is shorter than 1 cycle.
- Pulse `hold[0]` high for one cycle, aligned with a `ce_p` condition → that single `ce_p` is missing. The next `ce_p` appears on schedule, and `lvl[0]` and channel 1 are unchanged.
- `sel`=3 with W=3 → clamps to 2, giving period 8.
- Assert `reset` asynchronously between clock edges mid-period → all outputs go to 0 immediately, `cnt` restarts at 0, and the select reverts to `SEL_RST`.
